// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned SUB_WIDTH_DEFAULT = 32'd8;

endpackage

// File: rtl/prim_full_subtractor.sv
// Combinational one-bit full subtractor: diff = a - b - bor_in.
module prim_full_subtractor (
  input  logic a_in,
  input  logic b_in,
  input  logic bor_in,
  output logic diff_out,
  output logic bor_out
);

  assign diff_out = a_in ^ b_in ^ bor_in;
  assign bor_out  = (~a_in & b_in) | (~(a_in ^ b_in) & bor_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b) with start/done handshake.
// Optional signed-overflow output ovf_out is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'd1);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] areg_r;
  logic [WIDTH-1:0] breg_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             bw_r;
  logic             cell_diff_s;
  logic             cell_bor_s;
`ifdef SUB_OVERFLOW_EN
  logic [1:0]       msb_r;
`endif

  prim_full_subtractor u_cell (
    .a_in     (areg_r[0]),
    .b_in     (breg_r[0]),
    .bor_in   (bw_r),
    .diff_out (cell_diff_s),
    .bor_out  (cell_bor_s)
  );

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_in) state_next_s = SHIFT;
        else          state_next_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) state_next_s = DONE;
        else                   state_next_s = SHIFT;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Result register shifts right; the new difference bit enters at the MSB.
  always_comb begin
    res_next_s            = res_r >> 1;
    res_next_s[WIDTH-1]   = cell_diff_s;
  end

  // State register and registered busy flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r  <= IDLE;
      busy_out <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_out <= (state_next_s != IDLE);
    end
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      areg_r     <= '0;
      breg_r     <= '0;
      res_r      <= '0;
      cnt_r      <= '0;
      bw_r       <= 1'b0;
      done_out   <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      msb_r      <= 2'b00;
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            areg_r <= a_in;
            breg_r <= b_in;
            bw_r   <= 1'b0;
            cnt_r  <= '0;
`ifdef SUB_OVERFLOW_EN
            msb_r  <= {a_in[WIDTH-1], b_in[WIDTH-1]};
`endif
          end
        end
        SHIFT: begin
          done_out <= 1'b0;
          areg_r   <= areg_r >> 1;
          breg_r   <= breg_r >> 1;
          res_r    <= res_next_s;
          bw_r     <= cell_bor_s;
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        DONE: begin
          done_out   <= 1'b1;
          diff_out   <= res_r;
          borrow_out <= bw_r;
`ifdef SUB_OVERFLOW_EN
          // Overflow: operand signs differ and the result sign differs from a.
          ovf_out    <= (msb_r[1] != msb_r[0]) && (res_r[WIDTH-1] != msb_r[1]);
`endif
        end
        default: begin
          done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH cycles using one full-subtractor cell plus a registered borrow.
- Counterpart of the combinational full-adder datapath: subtraction instead of addition, and serial/area-minimal instead of parallel.
- Sits beside the adder blocks as a low-area arithmetic unit.
- Uses a start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk_in  input  1  clock; all logic is on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend; captured on an accepted start.
- b_in  input  WIDTH  subtrahend; captured on an accepted start.
- busy_out  output  1  high in SHIFT and DONE.
- done_out  output  1  one-cycle pulse when the result is valid.
- diff_out  output  WIDTH  a - b mod 2^WIDTH; held until the next completion.
- borrow_out  output  1  1 when unsigned a < b; held with diff_out.
- ovf_out  output  1  signed overflow; present only with SUB_OVERFLOW_EN.

Interface (already decided):
- One clock (clk_in).
- Reset rst_in is synchronous and active-high.

Behaviour:
- Reset (rst_in=1 at a clock edge) forces:
  - state IDLE;
  - busy_out=0, done_out=0, diff_out=0, borrow_out=0, ovf_out=0;
  - shift registers, borrow flop and counter cleared.
- Reset wins over any other event in the same cycle.
- Reset mid-operation aborts the computation; no done_out pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start_in=1, capture a_in->areg, b_in->breg; borrow flop=0; count=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Form bit d = areg[0]^breg[0]^bw.
  - Form bw_next = (~areg[0]&breg[0]) | (~(areg[0]^breg[0])&bw).
  - Shift areg and breg right by 1.
  - Shift d into the MSB of the result register, which also shifts right.
  - bw <= bw_next; count <= count+1.
  - When count==WIDTH-1, go to DONE.
- DONE (one cycle):
  - Load diff_out from the result register and borrow_out from bw.
  - Assert done_out for this cycle.
  - Return to IDLE.
- Latency: start accepted at edge 0 gives done_out high in the cycle after edge WIDTH+1, i.e. WIDTH+1 cycles from start to done. Throughput is one operation per WIDTH+2 cycles.
- start_in in SHIFT or DONE is ignored, with no queueing.
- start_in in IDLE in the same cycle that done_out drops is accepted normally.
- a_in/b_in are don't-care except in the accept cycle.
- Counter width is $clog2(WIDTH+1). count wraps only via reload on accept.
- WIDTH=1 edge case: SHIFT lasts exactly one cycle.
- diff_out and borrow_out change only in the DONE cycle. They are stable at all other times.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- With the macro defined:
  - Port ovf_out exists.
  - In DONE it loads (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs (kept in a 2-bit register).
  - It is held until the next completion and is 0 on reset.
- Without the macro: no port, no MSB register, no logic.

Decomposition:
- Shared package serial_arith_pkg holds:
  - FSM state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- Sub-module prim_full_subtractor (a_in, b_in, bor_in -> diff_out, bor_out) is the combinational bit cell. It is instantiated once; the FSM, shift registers and counter stay in the top.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse -> done_out exactly 9 cycles after the accept edge; diff_out=63, borrow_out=0; busy_out high for 9 cycles.
- a=5, b=10 -> diff_out=8'hFB, borrow_out=1; with SUB_OVERFLOW_EN, ovf_out=0.
- a=8'h80, b=8'h01 -> diff_out=8'h7F, borrow_out=0, ovf_out=1. Then a=0, b=0 -> diff_out=0, borrow_out=0, ovf_out=0.
- start_in held high throughout and a_in changed mid-op -> result uses only the first captured operands. Back-to-back operations then start every 10 cycles, and each done_out is one cycle wide.
- rst_in asserted 4 cycles into SHIFT -> next edge: busy_out=0, diff_out=0, and no done_out pulse. A new start after reset computes 200-55=145 correctly.
- WIDTH=1 instance: 0-1 -> diff=1, borrow=1, done 2 cycles after accept. 1-1 -> diff=0, borrow=0.
